// File: rtl/mem_pkg.sv
// Shared constants for the memory responder: FSM state encoding and wait-counter width.
package mem_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int CNT_W = 4;

endpackage

// File: rtl/mem_array.sv
// Storage array with asynchronous read and two write ports; the load port wins on collision.
module mem_array #(
  parameter int WIDTH   = 8,
  parameter int ADRBITS = 8
) (
  input  logic               clk,
  input  logic               load_we,
  input  logic [ADRBITS-1:0] load_adr,
  input  logic [WIDTH-1:0]   load_data,
  input  logic               acc_we,
  input  logic [ADRBITS-1:0] acc_adr,
  input  logic [WIDTH-1:0]   acc_wdata,
  output logic [WIDTH-1:0]   rd_data
);

  logic [WIDTH-1:0] mem_r [2**ADRBITS];

  // Array write, load port first.
  always_ff @(posedge clk) begin
    if (load_we) begin
      mem_r[load_adr] <= load_data;
    end else if (acc_we) begin
      mem_r[acc_adr] <= acc_wdata;
    end
  end

  assign rd_data = mem_r[acc_adr];

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: accepts one read/write at a time, inserts WAITS wait states,
// completes with a one-cycle memready pulse and keeps a sticky error flag.
module mem_responder
  import mem_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int ADRBITS = 8,
  parameter int WAITS   = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               memread,
  input  logic               memwrite,
  input  logic [WIDTH-1:0]   adr,
  input  logic [WIDTH-1:0]   writedata,
  output logic [WIDTH-1:0]   memdata,
  output logic               memready,
  output logic               busy,
  output logic               err,
  input  logic               load_en,
  input  logic [ADRBITS-1:0] load_adr,
  input  logic [WIDTH-1:0]   load_data
);

  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'((WAITS > 0) ? (WAITS - 1) : 0);

  logic [1:0]         state_r, state_nxt_s;
  logic [CNT_W-1:0]   cnt_r;
  logic [ADRBITS-1:0] adr_r;
  logic [WIDTH-1:0]   wdata_r;
  logic               wr_r, oor_r;
  logic [WIDTH-1:0]   memdata_r;
  logic               memready_r, busy_r, err_r;

  logic               req_s, both_s, oor_s, access_s;
  logic [ADRBITS-1:0] acc_adr_s;
  logic [WIDTH-1:0]   acc_wdata_s, rd_data_s;
  logic               acc_wr_s, acc_oor_s, acc_we_s, load_we_s;

  assign req_s  = memread ^ memwrite;
  assign both_s = memread & memwrite;
  assign oor_s  = (adr >> ADRBITS) != {WIDTH{1'b0}};

  // With no wait states the access happens on the acceptance edge, so use the live request.
  assign acc_adr_s   = (state_r == IDLE) ? adr[ADRBITS-1:0] : adr_r;
  assign acc_wdata_s = (state_r == IDLE) ? writedata : wdata_r;
  assign acc_wr_s    = (state_r == IDLE) ? memwrite : wr_r;
  assign acc_oor_s   = (state_r == IDLE) ? oor_s : oor_r;

  assign acc_we_s  = access_s & acc_wr_s & ~acc_oor_s & rst;
  assign load_we_s = load_en & rst;

  // Next-state logic; access_s marks the edge that enters DONE.
  always_comb begin
    state_nxt_s = state_r;
    access_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (req_s) begin
          if (WAITS == 0) begin
            state_nxt_s = DONE;
            access_s    = 1'b1;
          end else begin
            state_nxt_s = WAIT;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WAIT: begin
        if (cnt_r == {CNT_W{1'b0}}) begin
          state_nxt_s = DONE;
          access_s    = 1'b1;
        end else begin
          state_nxt_s = WAIT;
        end
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM, capture registers, registered outputs and sticky error.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r    <= IDLE;
      cnt_r      <= {CNT_W{1'b0}};
      adr_r      <= {ADRBITS{1'b0}};
      wdata_r    <= {WIDTH{1'b0}};
      wr_r       <= 1'b0;
      oor_r      <= 1'b0;
      memdata_r  <= {WIDTH{1'b0}};
      memready_r <= 1'b0;
      busy_r     <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      memready_r <= access_s;
      busy_r     <= (state_nxt_s != IDLE);
      if (state_r == IDLE && req_s) begin
        adr_r   <= adr[ADRBITS-1:0];
        wdata_r <= writedata;
        wr_r    <= memwrite;
        oor_r   <= oor_s;
        cnt_r   <= WAIT_LOAD;
      end else if (state_r == WAIT && cnt_r != {CNT_W{1'b0}}) begin
        cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (access_s && !acc_wr_s) begin
        memdata_r <= acc_oor_s ? {WIDTH{1'b0}} : rd_data_s;
      end
      if ((state_r == IDLE && both_s) || (access_s && acc_oor_s)) begin
        err_r <= 1'b1;
      end
    end
  end

  mem_array #(
    .WIDTH   (WIDTH),
    .ADRBITS (ADRBITS)
  ) u_array (
    .clk       (clk),
    .load_we   (load_we_s),
    .load_adr  (load_adr),
    .load_data (load_data),
    .acc_we    (acc_we_s),
    .acc_adr   (acc_adr_s),
    .acc_wdata (acc_wdata_s),
    .rd_data   (rd_data_s)
  );

  assign memdata  = memdata_r;
  assign memready = memready_r;
  assign busy     = busy_r;
  assign err      = err_r;

endmodule
